// File: rtl/fitness_sequencer.sv
// fitness_sequencer: presents each population tour to the distance calculator and tracks the fittest
// Ports: clk, rst (async active-high)
//   pop_we/pop_waddr/pop_wdata  tour load, dropped while busy
//   eval_start/busy/eval_done   sweep control
//   best_idx/best_dist          minimum distance and its index from the last sweep
//   fit_raddr/fit_rdata         combinational fitness readback
//   calc_tour/calc_start/calc_dist/calc_done  calculator handshake
//   err                         watchdog flag
// Optional: FITNESS_WATCHDOG_EN bounds each calculator wait to TIMEOUT cycles.
module fitness_sequencer #(
  parameter int POP_SIZE = 8,
  parameter int IDX_W    = 3,
  parameter int TOUR_W   = 150,
  parameter int DIST_W   = 12,
  parameter int TIMEOUT  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pop_we,
  input  logic [IDX_W-1:0]  pop_waddr,
  input  logic [TOUR_W-1:0] pop_wdata,
  input  logic              eval_start,
  output logic              busy,
  output logic              eval_done,
  output logic [IDX_W-1:0]  best_idx,
  output logic [DIST_W-1:0] best_dist,
  input  logic [IDX_W-1:0]  fit_raddr,
  output logic [DIST_W-1:0] fit_rdata,
  output logic [TOUR_W-1:0] calc_tour,
  output logic              calc_start,
  input  logic [DIST_W-1:0] calc_dist,
  input  logic              calc_done,
  output logic              err
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, STORE, DONE} state_t;
  state_t r_state;
  logic [IDX_W-1:0] r_idx;
  logic [DIST_W-1:0] r_cap;
  logic [DIST_W-1:0] r_fit [POP_SIZE];
  logic [TOUR_W-1:0] r_pop [POP_SIZE];
  logic w_last;
  assign w_last = r_idx == IDX_W'(POP_SIZE - 1);
  assign calc_tour = r_pop[r_idx];
  assign fit_rdata = r_fit[fit_raddr];
`ifdef FITNESS_WATCHDOG_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] r_cnt;
  logic w_tmo;
  assign w_tmo = r_cnt == CNT_W'(TIMEOUT - 1);
`else
  assign err = 1'b0;
`endif
  always_ff @(posedge clk) if (pop_we && !busy) r_pop[pop_waddr] <= pop_wdata;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx <= '0;
      r_cap <= '0;
      busy <= 1'b0;
      eval_done <= 1'b0;
      calc_start <= 1'b0;
      best_idx <= '0;
      best_dist <= '1;
      for (int i = 0; i < POP_SIZE; i++) r_fit[i] <= '1;
`ifdef FITNESS_WATCHDOG_EN
      r_cnt <= '0;
      err <= 1'b0;
`endif
    end else begin
      calc_start <= 1'b0;
      eval_done <= 1'b0;
      case (r_state)
        IDLE: if (eval_start) begin
          r_state <= ISSUE;
          r_idx <= '0;
          best_idx <= '0;
          best_dist <= '1;
          busy <= 1'b1;
`ifdef FITNESS_WATCHDOG_EN
          err <= 1'b0;
`endif
        end
        ISSUE: begin
          calc_start <= 1'b1;
          r_state <= WAIT;
`ifdef FITNESS_WATCHDOG_EN
          r_cnt <= '0;
`endif
        end
        WAIT: begin
          if (calc_done) begin
            r_cap <= calc_dist;
            r_state <= STORE;
          end
`ifdef FITNESS_WATCHDOG_EN
          else if (w_tmo) begin
            r_fit[r_idx] <= '1;
            err <= 1'b1;
            r_idx <= w_last ? r_idx : r_idx + 1'b1;
            eval_done <= w_last;
            r_state <= w_last ? DONE : ISSUE;
          end else r_cnt <= r_cnt + 1'b1;
`endif
        end
        STORE: begin
          r_fit[r_idx] <= r_cap;
          best_dist <= r_cap < best_dist ? r_cap : best_dist;
          best_idx <= r_cap < best_dist ? r_idx : best_idx;
          r_idx <= w_last ? r_idx : r_idx + 1'b1;
          eval_done <= w_last;
          r_state <= w_last ? DONE : ISSUE;
        end
        DONE: begin
          busy <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/fitness_sequencer.md
Name: fitness_sequencer

Overview:
Initiator side of the tour-distance start/done handshake. Holds a population of POP_SIZE encoded tours and presents each tour in turn to the distance calculator. It captures each returned distance into a fitness array and tracks the minimum distance and its index. It sits between the GA population/crossover logic and the distance calculator, and issues one eval_done pulse per population sweep.

Parameters:
POP_SIZE, 8, number of tours held and evaluated per sweep (2..256)
IDX_W, 3, index width, equal to clog2(POP_SIZE)
TOUR_W, 150, width of one encoded tour (30 cities x 5 bits)
DIST_W, 12, width of a distance/fitness value
TIMEOUT, 64, per-tour watchdog limit in cycles (used only with the optional feature)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
pop_we  in  1  population write strobe; honoured only when busy=0
pop_waddr  in  IDX_W  population write index
pop_wdata  in  TOUR_W  tour to store
eval_start  in  1  begin a sweep; sampled only in IDLE
busy  out  1  high from the cycle after accepted eval_start until eval_done
eval_done  out  1  one-cycle pulse at end of sweep
best_idx  out  IDX_W  index of the minimum-distance tour from the last sweep
best_dist  out  DIST_W  minimum distance from the last sweep
fit_raddr  in  IDX_W  fitness read index
fit_rdata  out  DIST_W  fitness[fit_raddr], combinational read
calc_tour  out  TOUR_W  tour presented to the calculator
calc_start  out  1  one-cycle start pulse to the calculator
calc_dist  in  DIST_W  distance returned by the calculator
calc_done  in  1  one-cycle done pulse from the calculator
err  out  1  watchdog flag (tied 0 when the optional feature is off)

Behaviour:
- Reset values: busy=0, eval_done=0, calc_start=0, best_idx=0, best_dist=all-ones, err=0, idx=0, state=IDLE. Fitness array resets to all-ones. Population storage is not reset.
- States and transitions:
  - IDLE: eval_start=1 -> ISSUE with idx=0 and best_dist=all-ones.
  - ISSUE: calc_start=1 for exactly 1 cycle -> WAIT.
  - WAIT: calc_done=1 -> STORE, with calc_dist registered on that edge.
  - STORE: fitness[idx] <= captured distance.
    - If captured distance < best_dist (strict), update best_dist and best_idx. On ties the lowest index wins.
    - If idx == POP_SIZE-1 -> DONE; otherwise idx+1 -> ISSUE.
  - DONE: eval_done=1 for 1 cycle -> IDLE.
- calc_tour = pop[idx]. It is held stable from the ISSUE cycle through the calc_done cycle.
- Spacing: calc_start is never issued in the same cycle as, or the cycle after, calc_done. STORE provides the gap the calculator needs to return to its hold state.
- calc_done while not in WAIT is ignored.
- eval_start while busy is ignored; no queuing.
- pop_we while busy is dropped, so the population cannot change mid-sweep.
- Latency: a sweep takes POP_SIZE*(Tcalc+3)+1 cycles from the accepted eval_start to eval_done, where Tcalc is the number of cycles from calc_start to calc_done.
- best_idx and best_dist are valid from eval_done until the next accepted eval_start.
- Reset mid-sweep: immediate return to reset values. Partial fitness results are discarded, and calc_start drops at once.
- Distance values are unsigned, with no arithmetic beyond the compare.

Optional Feature:
FITNESS_WATCHDOG_EN
- Defined: a cycle counter runs in WAIT. If it reaches TIMEOUT without calc_done:
  - fitness[idx] is set to all-ones;
  - err is set sticky until the next accepted eval_start or rst;
  - the sequencer proceeds as if STORE had occurred (compare skipped).
  The counter clears on every ISSUE.
- Undefined: no counter, err tied 0, and WAIT waits indefinitely.

Test Plan:
1. Reset, load tours 0..7, eval_start. The calculator model returns distances 300,120,450,120,999,87,600,87 with Tcalc=31 -> eval_done after 8*34+1=273 cycles; best_idx=5, best_dist=87 (tie with idx7 resolved to the lower index); fit_rdata[2]=450.
2. Check each calc_start pulse: 1 cycle wide, calc_tour equals pop[idx] and is stable until calc_done, and at least 2 cycles separate calc_done from the next calc_start.
3. Pulse eval_start and pop_we (addr 0, new data) mid-sweep -> both ignored; the sweep completes unchanged and pop[0] keeps its old value.
4. Assert rst during WAIT of idx 3 -> busy=0, calc_start=0, best_dist=0xFFF, fit_rdata[0]=0xFFF. A following eval_start runs a full sweep from idx 0.
5. All distances = 0xFFF -> best_idx=0, best_dist=0xFFF.
6. With FITNESS_WATCHDOG_EN and TIMEOUT=64, the model never answers idx 2 -> fitness[2]=0xFFF, err=1, and the sweep finishes. The next eval_start clears err.
